// File: rtl/iter_shape_scheduler_if.sv
// Handshake bundle between frame timing, iter_shape_scheduler and the line scanner.
// master drives frame control and scanner status; slave is the scheduler itself.
interface iter_shape_scheduler_if #(
  parameter int NSHAPE = 7,
  parameter int IDW    = (NSHAPE > 1) ? $clog2(NSHAPE) : 1,
  parameter int CNTW   = 8
);
  logic              frame_start;
  logic [NSHAPE-1:0] shape_en;
  logic              abort;
  logic              scan_start;
  logic              scan_busy;
  logic              scan_done;
  logic [IDW-1:0]    shape_id;
  logic              shape_valid;
  logic              busy;
  logic              frame_done;
  logic              aborted;
  logic              overrun;
  logic [CNTW-1:0]   overrun_cnt;
  logic              ovr_clear;

  modport master (
    output frame_start, shape_en, abort, scan_busy, scan_done, ovr_clear,
    input  scan_start, shape_id, shape_valid, busy, frame_done, aborted,
           overrun, overrun_cnt
  );

  modport slave (
    input  frame_start, shape_en, abort, scan_busy, scan_done, ovr_clear,
    output scan_start, shape_id, shape_valid, busy, frame_done, aborted,
           overrun, overrun_cnt
  );
endinterface

// File: rtl/iter_shape_scheduler.sv
// Frame sequencer: walks enabled shapes lowest index first and runs one line-scanner
// pass per shape, with abort/drain handling and a saturating dropped-frame counter.
module iter_shape_scheduler #(
  parameter int NSHAPE = 7,
  parameter int IDW    = (NSHAPE > 1) ? $clog2(NSHAPE) : 1,
  parameter int CNTW   = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  iter_shape_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_DRAIN  = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t            state_r, next_state_s;
  logic [NSHAPE-1:0] pend_r;
  logic [IDW-1:0]    shape_id_r;
  logic              scan_start_r, shape_valid_r, busy_r, frame_done_r;
  logic              aborted_r, overrun_r;
  logic [CNTW-1:0]   overrun_cnt_r;
  logic              accept_s, drop_s, abort_take_s;

  function automatic logic [IDW-1:0] lowest_idx(input logic [NSHAPE-1:0] m);
    lowest_idx = {IDW{1'b0}};
    for (int i = NSHAPE - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDW'(i);
      else      lowest_idx = lowest_idx;
    end
  endfunction

  assign accept_s     = bus.frame_start && (state_r == S_IDLE);
  assign drop_s       = bus.frame_start && (state_r != S_IDLE);
  assign abort_take_s = bus.abort && ((state_r == S_SELECT) || (state_r == S_START) ||
                                      (state_r == S_WAIT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state decode; abort outranks scan_done and pending work
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:   if (bus.frame_start) next_state_s = S_SELECT;
                else                 next_state_s = S_IDLE;
      S_SELECT: if (bus.abort)                      next_state_s = S_DRAIN;
                else if (pend_r == {NSHAPE{1'b0}})  next_state_s = S_FIN;
                else                                next_state_s = S_START;
      S_START:  if (bus.abort) next_state_s = S_DRAIN;
                else           next_state_s = S_WAIT;
      S_WAIT:   if (bus.abort)          next_state_s = S_DRAIN;
                else if (bus.scan_done) next_state_s = S_SELECT;
                else                    next_state_s = S_WAIT;
      S_DRAIN:  if (!bus.scan_busy && !bus.scan_done) next_state_s = S_FIN;
                else                                  next_state_s = S_DRAIN;
      S_FIN:    next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Moore outputs registered from the next state so they line up with the state itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_start_r  <= 1'b0;
      shape_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      aborted_r     <= 1'b0;
    end else begin
      scan_start_r  <= (next_state_s == S_START);
      shape_valid_r <= (next_state_s == S_START) || (next_state_s == S_WAIT);
      busy_r        <= (next_state_s != S_IDLE);
      frame_done_r  <= (next_state_s == S_FIN);
      if (accept_s)          aborted_r <= 1'b0;
      else if (abort_take_s) aborted_r <= 1'b1;
      else                   aborted_r <= aborted_r;
    end
  end

  // Pending-shape mask and current shape index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r     <= {NSHAPE{1'b0}};
      shape_id_r <= {IDW{1'b0}};
    end else if (accept_s) begin
      pend_r     <= bus.shape_en;
      shape_id_r <= shape_id_r;
    end else if ((state_r == S_SELECT) && !bus.abort && (pend_r != {NSHAPE{1'b0}})) begin
      pend_r     <= pend_r & (pend_r - NSHAPE'(1));
      shape_id_r <= lowest_idx(pend_r);
    end else begin
      pend_r     <= pend_r;
      shape_id_r <= shape_id_r;
    end
  end

  // Sticky overrun flag and saturating drop counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r     <= 1'b0;
      overrun_cnt_r <= {CNTW{1'b0}};
    end else if (bus.ovr_clear) begin
      overrun_r     <= 1'b0;
      overrun_cnt_r <= {CNTW{1'b0}};
    end else if (drop_s) begin
      overrun_r     <= 1'b1;
      if (overrun_cnt_r == {CNTW{1'b1}}) overrun_cnt_r <= overrun_cnt_r;
      else                               overrun_cnt_r <= overrun_cnt_r + CNTW'(1);
    end else begin
      overrun_r     <= overrun_r;
      overrun_cnt_r <= overrun_cnt_r;
    end
  end

  // Output drive; an abort seen during START masks that cycle's start pulse
  always_comb begin
    bus.scan_start  = scan_start_r & ~bus.abort;
    bus.shape_id    = shape_id_r;
    bus.shape_valid = shape_valid_r;
    bus.busy        = busy_r;
    bus.frame_done  = frame_done_r;
    bus.aborted     = aborted_r;
    bus.overrun     = overrun_r;
    bus.overrun_cnt = overrun_cnt_r;
  end

endmodule
